// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, mid-bit sampling, LSB-first word,
// one-cycle done / framing-error strobes.
module uart_rx #(
    parameter int unsigned p_CLK_DIV  = 104,
    parameter int unsigned p_WORD_LEN = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    output logic [p_WORD_LEN-1:0] o_data,
    output logic                  o_done,
    output logic                  o_frame_err,
    output logic                  o_active
);

    localparam int unsigned CW   = $clog2(p_CLK_DIV + 1);
    localparam int unsigned BW   = $clog2(p_WORD_LEN + 1);
    localparam int unsigned HALF = p_CLK_DIV / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                r_state;
    logic                  r_meta;
    logic                  r_rx;
    logic [CW-1:0]         r_clk_count;
    logic [BW-1:0]         r_bit_count;
    logic [p_WORD_LEN-1:0] r_shift;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_rx   <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_rx   <= r_meta;
        end
    end

    // Receive FSM; strobes default low every cycle so they last exactly one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_clk_count <= '0;
            r_bit_count <= '0;
            r_shift     <= '0;
            o_data      <= '0;
            o_done      <= 1'b0;
            o_frame_err <= 1'b0;
            o_active    <= 1'b0;
        end else begin
            o_done      <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    o_active    <= 1'b0;
                    r_clk_count <= '0;
                    r_bit_count <= '0;
                    if (!r_rx) begin
                        r_state  <= S_START;
                        o_active <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_clk_count == CW'(HALF - 1)) begin
                        r_clk_count <= '0;
                        if (!r_rx) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state  <= S_IDLE;
                            o_active <= 1'b0;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_clk_count == CW'(p_CLK_DIV - 1)) begin
                        r_clk_count <= '0;
                        for (int i = 0; i < int'(p_WORD_LEN); i++) begin
                            if (r_bit_count == BW'(i)) r_shift[i] <= r_rx;
                        end
                        if (r_bit_count == BW'(p_WORD_LEN - 1)) begin
                            r_bit_count <= '0;
                            r_state     <= S_STOP;
                        end else begin
                            r_bit_count <= r_bit_count + BW'(1);
                        end
                    end else begin
                        r_clk_count <= r_clk_count + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_clk_count == CW'(p_CLK_DIV - 1)) begin
                        r_clk_count <= '0;
                        o_active    <= 1'b0;
                        if (r_rx) begin
                            o_data  <= r_shift;
                            o_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + CW'(1);
                    end
                end
                S_BREAK: begin
                    // A held-low line must return high before a new start is accepted.
                    if (r_rx) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a bit-banged serial driver queues expected
// strobes, a negedge monitor pops and compares them.
module tb_uart_rx;

    localparam int unsigned CLK_DIV = 104;
    localparam int unsigned W       = 8;
    localparam int unsigned HALF    = CLK_DIV / 2;
    localparam int          LAT     = 2 + int'(HALF) + int'((W + 1) * CLK_DIV);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx  = 1'b1;
    logic [W-1:0] data;
    logic         done;
    logic         ferr;
    logic         active;

    uart_rx #(.p_CLK_DIV(CLK_DIV), .p_WORD_LEN(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_done      (done),
        .o_frame_err (ferr),
        .o_active    (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         err;
        logic [W-1:0] data;
        int           start_cyc;
        bit           chk_lat;
    } exp_t;

    exp_t         q[$];
    exp_t         m;
    int           n_tests   = 0;
    int           n_fail    = 0;
    int           cycle     = 0;
    int           lat_d;
    logic [W-1:0] last_good = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic bit_period(input logic b);
        rx = b;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop, input bit chk_lat, input bit chk_act);
        exp_t e;
        e.err       = !stop;
        e.data      = stop ? d : last_good;
        e.start_cyc = cycle;
        e.chk_lat   = chk_lat;
        q.push_back(e);
        if (stop) last_good = d;
        bit_period(1'b0);
        for (int i = 0; i < int'(W); i++) begin
            bit_period(d[i]);
            if (chk_act && i == 3) chk("active_mid_frame", 32'(active), 32'd1);
        end
        bit_period(stop);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done && ferr) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_exclusive: done=1 frame_err=1, expected at most one high");
        end else if (done || ferr) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: done=%0b frame_err=%0b, expected none", done, ferr);
            end else begin
                m = q.pop_front();
                chk("strobe_kind_frame_err", 32'(ferr), 32'(m.err));
                chk("strobe_data", 32'(data), 32'(m.data));
                if (m.chk_lat) begin
                    lat_d = cycle - m.start_cyc;
                    n_tests++;
                    if (lat_d < LAT - 1 || lat_d > LAT + 1) begin
                        n_fail++;
                        $display("FAIL done_latency: got %0d cycles, expected %0d +/-1", lat_d, LAT);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] w;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_frame_err", 32'(ferr), 32'd0);
        chk("reset_active", 32'(active), 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Nominal frame with latency and active-window checks.
        chk("active_idle", 32'(active), 32'd0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        chk("active_after_frame", 32'(active), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("nominal_data", 32'(data), 32'hA5);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_last_data", 32'(data), 32'h3C);

        // Short low glitch must not start a frame.
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("glitch_active", 32'(active), 32'd0);
        chk("glitch_data", 32'(data), 32'(last_good));

        // Framing error followed by a long break, then a good frame.
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("ferr_data_held", 32'(data), 32'h3C);
        chk("ferr_active", 32'(active), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);

        // Reset during bit 4 of 0x81.
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(1'b1 & (i == 0));
        rx = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_data", 32'(data), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_frame_err", 32'(ferr), 32'd0);
        chk("midreset_active", 32'(active), 32'd0);
        last_good = '0;
        // The still-low tail looks like a start bit; holding the line low
        // through its stop sample turns it into a framing error, never a done.
        m.err = 1'b1; m.data = '0; m.start_cyc = 0; m.chk_lat = 1'b0;
        q.push_back(m);
        repeat (CLK_DIV - HALF - 1) @(posedge clk);
        #1;
        bit_period(1'b0);
        bit_period(1'b0);
        bit_period(1'b1);
        bit_period(1'b1);
        rx = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_data", 32'(data), 32'h7E);

        // Random words back to back.
        for (int k = 0; k < 16; k++) begin
            w = W'($urandom());
            send_frame(w, 1'b1, 1'b0, 1'b0);
        end

        for (int k = 0; k < 2000 && q.size() != 0; k++) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("final_data", 32'(data), 32'(last_good));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
